// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha256_pkg
// Brief    : Shared SHA-256 word type, block constants and schedule sigmas.
// Revision : 1.0 - initial release
// ============================================================================
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int BLOCK_WORDS = 16;
    localparam int ROUNDS      = 64;

    function automatic word_t small_sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_schedule
// Brief    : SHA-256 message schedule expander; emits W[0..63] for one padded
//            block over a valid/ready stream. Optional SHA256_SCHED_ROUND_IDX_EN
//            adds a round_idx output.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_msg_schedule
    import sha256_pkg::word_t, sha256_pkg::BLOCK_WORDS,
           sha256_pkg::small_sigma0, sha256_pkg::small_sigma1;
#(
    parameter int BLOCK_BITS = 512,
    parameter int ROUNDS     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BLOCK_BITS-1:0] blk_data,
    input  logic                  blk_valid,
    output logic                  blk_ready,
    output logic [31:0]           w_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic                  w_last
`ifdef SHA256_SCHED_ROUND_IDX_EN
    ,
    output logic [5:0]            round_idx
`endif
);

    localparam int c_T_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    if (BLOCK_BITS != 512) begin : g_bad_block_bits
        $error("sha256_msg_schedule: BLOCK_BITS must be 512");
    end

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [c_T_W-1:0] r_t;
    word_t            r_window [BLOCK_WORDS];
    logic             w_load;
    logic             w_fire;
    logic             w_at_end;
    logic             w_final;
    word_t            w_new;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        blk_ready   = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    w_state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                w_valid = 1'b1;
                if (w_final) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_load   = (r_state == IDLE) && blk_valid;
    assign w_fire   = w_valid && w_ready;
    assign w_at_end = (r_t == c_T_W'(ROUNDS - 1));
    assign w_final  = w_fire && w_at_end;
    assign w_last   = w_valid && w_at_end;
    assign w_data   = r_window[0];

    // Window slot k holds W[t+k]; the new tail word is W[t+16].
    assign w_new = small_sigma1(r_window[14]) + r_window[9]
                 + small_sigma0(r_window[1]) + r_window[0];

    always_ff @(posedge clk) begin
        if (rst || w_load || w_final) begin
            r_t <= '0;
        end else if (w_fire) begin
            r_t <= r_t + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                r_window[i] <= '0;
            end
        end else if (w_load) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                r_window[i] <= blk_data[BLOCK_BITS-1-32*i -: 32];
            end
        end else if (w_fire) begin
            for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
                r_window[i] <= r_window[i+1];
            end
            r_window[BLOCK_WORDS-1] <= w_new;
        end
    end

`ifdef SHA256_SCHED_ROUND_IDX_EN
    assign round_idx = w_valid ? 6'(r_t) : 6'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_msg_schedule
// Brief    : Self-checking bench for sha256_msg_schedule against a behavioural
//            schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_schedule;

    typedef logic [31:0] blk_t [16];

    typedef struct {
        string       name;
        int          which;   // 0 = "abc" capture, 1 = all-ones capture
        int          idx;
        logic [31:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic [31:0]  w_data;
    logic         w_valid;
    logic         w_ready;
    logic         w_last;
`ifdef SHA256_SCHED_ROUND_IDX_EN
    logic [5:0]   round_idx;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_w [64];
    logic [31:0] got     [64];
    logic [31:0] abc_got [64];
    logic [31:0] ones_got[64];

    sha256_msg_schedule #(.BLOCK_BITS(512), .ROUNDS(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .w_data    (w_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_last    (w_last)
`ifdef SHA256_SCHED_ROUND_IDX_EN
        ,
        .round_idx (round_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule straight from the FIPS 180-4 recurrence.
    task automatic compute_model(input blk_t b);
        logic [63:0] sum;
        for (int t = 0; t < 16; t++) model_w[t] = b[t];
        for (int t = 16; t < 64; t++) begin
            sum = 64'(rotr(model_w[t-2], 17) ^ rotr(model_w[t-2], 19) ^ (model_w[t-2] >> 10))
                + 64'(model_w[t-7])
                + 64'(rotr(model_w[t-15], 7) ^ rotr(model_w[t-15], 18) ^ (model_w[t-15] >> 3))
                + 64'(model_w[t-16]);
            model_w[t] = sum[31:0];
        end
    endtask

    function automatic logic [511:0] pack(input blk_t b);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[511-32*i -: 32] = b[i];
        return v;
    endfunction

    // Feed one block from IDLE and collect 64 words; ready_pct sets w_ready duty.
    task automatic run_block(input blk_t b, input int ready_pct, input string tag);
        int          idx;
        int          cyc;
        logic        stalled;
        logic [31:0] prev;
        compute_model(b);
        @(negedge clk);
        blk_data  = pack(b);
        blk_valid = 1'b1;
        w_ready   = 1'b0;
        @(negedge clk);
        blk_valid = 1'b0;
        idx = 0; cyc = 0; stalled = 1'b0; prev = '0;
        while (idx < 64 && cyc < 2000) begin
            check({tag, " w_valid in block"}, w_valid, 1'b1);
            if (w_valid) begin
                if (stalled) check({tag, " stall hold"}, w_data, prev);
                check({tag, " w_last"}, w_last, (idx == 63));
                check({tag, " blk_ready low"}, blk_ready, 1'b0);
`ifdef SHA256_SCHED_ROUND_IDX_EN
                check({tag, " round_idx"}, round_idx, idx[5:0]);
`endif
                got[idx] = w_data;
                w_ready  = ($urandom_range(99) < ready_pct);
                if (w_ready) begin
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    prev    = w_data;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, " completed in budget"}, (idx == 64), 1'b1);
        w_ready = 1'b0;
        check({tag, " w_valid after last"}, w_valid, 1'b0);
        check({tag, " w_last after last"}, w_last, 1'b0);
        check({tag, " blk_ready after last"}, blk_ready, 1'b1);
        for (int i = 0; i < 64; i++) check({tag, " word"}, got[i], model_w[i]);
    endtask

    initial begin
        blk_t abc;
        blk_t ones;
        blk_t rnd;
        vec_t vecs[6];
        int   nwords;

        vecs[0] = '{"abc W0",   0, 0,  32'h61626380};
        vecs[1] = '{"abc W15",  0, 15, 32'h00000018};
        vecs[2] = '{"abc W16",  0, 16, 32'h61626380};
        vecs[3] = '{"abc W17",  0, 17, 32'h000F0000};
        vecs[4] = '{"ones W0",  1, 0,  32'hFFFFFFFF};
        vecs[5] = '{"ones W16", 1, 16, 32'h203FFFFC};

        for (int i = 0; i < 16; i++) abc[i] = '0;
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;
        for (int i = 0; i < 16; i++) ones[i] = 32'hFFFFFFFF;

        rst = 1'b1; blk_valid = 1'b0; blk_data = '0; w_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset w_valid", w_valid, 1'b0);
        check("reset w_last", w_last, 1'b0);
        check("reset blk_ready", blk_ready, 1'b1);
        check("reset w_data", w_data, 32'h0);
`ifdef SHA256_SCHED_ROUND_IDX_EN
        check("reset round_idx", round_idx, 6'd0);
`endif
        rst = 1'b0;

        run_block(abc, 100, "abc");
        for (int i = 0; i < 64; i++) abc_got[i] = got[i];
        run_block(abc, 50, "abc stall");
        run_block(ones, 100, "ones");
        for (int i = 0; i < 64; i++) ones_got[i] = got[i];

        foreach (vecs[i]) begin
            check(vecs[i].name, (vecs[i].which == 0) ? abc_got[vecs[i].idx] : ones_got[vecs[i].idx],
                  vecs[i].exp);
        end

        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 16; i++) rnd[i] = $urandom;
            run_block(rnd, 30 + 30 * n, "random");
        end

        // Back-to-back: blk_valid stays high across two blocks.
        for (int i = 0; i < 16; i++) rnd[i] = $urandom;
        compute_model(rnd);
        @(negedge clk);
        blk_data = pack(rnd); blk_valid = 1'b1; w_ready = 1'b1;
        nwords = 0;
        for (int k = 0; k < 131; k++) begin
            @(negedge clk);
            if (w_valid) nwords++;
            if (k < 64 || (k >= 65 && k <= 128)) begin
                check("b2b w_valid", w_valid, 1'b1);
                check("b2b blk_ready", blk_ready, 1'b0);
                check("b2b w_data", w_data, model_w[(k < 64) ? k : k - 65]);
                check("b2b w_last", w_last, (k == 63 || k == 128));
            end else begin
                check("b2b idle w_valid", w_valid, 1'b0);
                check("b2b idle blk_ready", blk_ready, 1'b1);
            end
            if (k == 128) blk_valid = 1'b0;
        end
        check("b2b word count", nwords, 128);
        w_ready = 1'b0;

        // Mid-block reset after word 20 is accepted.
        compute_model(abc);
        @(negedge clk);
        blk_data = pack(abc); blk_valid = 1'b1; w_ready = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        repeat (21) @(negedge clk);
        check("pre-reset W21", w_data, model_w[21]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid rst w_valid", w_valid, 1'b0);
        check("mid rst blk_ready", blk_ready, 1'b1);
        check("mid rst w_last", w_last, 1'b0);
        check("mid rst w_data", w_data, 32'h0);
        repeat (3) begin
            @(negedge clk);
            check("mid rst no words", w_valid, 1'b0);
        end
        w_ready = 1'b0;
        run_block(abc, 100, "abc after rst");
        check("restart W0", got[0], 32'h61626380);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
